// File: rtl/mu0_control.sv
// MU0 control sequencer: fetch/execute FSM with memory wait states and opcode decode.
// Optional instruction counter output enabled by defining MU0_INSTR_COUNT_EN.
module mu0_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       acc_n,
  input  logic       acc_z,
  input  logic       mem_ready,
  output logic       addr_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic [1:0] alu_fs,
  output logic       acc_en,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
`ifdef MU0_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    addr_sel = 1'b0;
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    alu_fs   = 2'b00;
    acc_en   = 1'b0;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_en  = 1'b1;
          pc_en  = 1'b1;
          x_sel  = 1'b1;
          alu_fs = 2'b10;
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          4'h0, 4'h2, 4'h3: begin
            addr_sel = 1'b1;
            mem_rd   = 1'b1;
            alu_fs   = (opcode == 4'h0) ? 2'b00 :
                       (opcode == 4'h2) ? 2'b01 : 2'b11;
            acc_en   = mem_ready;
            if (mem_ready) w_next = S_FETCH;
          end
          4'h1: begin
            addr_sel = 1'b1;
            mem_wr   = 1'b1;
            if (mem_ready) w_next = S_FETCH;
          end
          4'h4, 4'h5, 4'h6: begin
            y_sel  = 1'b1;
            pc_en  = (opcode == 4'h4) ? 1'b1 :
                     (opcode == 4'h5) ? !acc_n : !acc_z;
            w_next = S_FETCH;
          end
          4'h7:    w_next = S_HALT;
          default: w_next = S_FETCH;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
    // Reset forces every output low without waiting for the state register.
    if (!reset_n) begin
      addr_sel = 1'b0;
      x_sel    = 1'b0;
      y_sel    = 1'b0;
      alu_fs   = 2'b00;
      acc_en   = 1'b0;
      pc_en    = 1'b0;
      ir_en    = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      halted   = 1'b0;
    end
  end

`ifdef MU0_INSTR_COUNT_EN
  logic r_count;
  logic [15:0] r_instr_count;
  logic w_leave_exec;

  assign w_leave_exec = (r_state == S_EXEC) && (w_next != S_EXEC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_instr_count <= '0;
    else if (w_leave_exec) r_instr_count <= r_instr_count + 16'd1;
  end

  assign r_count     = 1'b0;
  assign instr_count = r_instr_count;
`endif

endmodule

// File: doc/mu0_control.md
# mu0_control

Control sequencer for the MU0 16-bit processor. Runs a two-phase fetch/execute state machine with memory wait-state handshaking, and decodes the 4-bit opcode held in IR. Drives the select line of each 16-bit 2:1 datapath mux (address source, ALU X, ALU Y), the register load enables, the ALU function and the memory strobes. Sits directly upstream of the mu0_mux16 instances and consumes the N/Z flags from the accumulator.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- opcode  input  4  IR[15:12], stable throughout EXEC
- acc_n  input  1  accumulator negative flag (ACC[15])
- acc_z  input  1  accumulator zero flag (ACC == 0)
- mem_ready  input  1  memory completes the current access this cycle
- addr_sel  output  1  address mux select: 0 = PC, 1 = IR[11:0]
- x_sel  output  1  ALU X mux select: 0 = ACC, 1 = PC
- y_sel  output  1  ALU Y mux select: 0 = memory read data, 1 = IR operand
- alu_fs  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X−Y
- acc_en  output  1  accumulator load
- pc_en  output  1  PC load
- ir_en  output  1  IR load
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- halted  output  1  processor stopped by STP

## Operation
- States: FETCH, EXEC, HALT. The state register resets to FETCH.
- Outputs are combinational from state, opcode, flags and mem_ready. Any output not listed for a state/opcode is 0.

FETCH:
- Drives addr_sel=0 and mem_rd=1.
- While mem_ready=0: stays in FETCH, strobes held stable, all enables 0.
- On mem_ready=1: ir_en=1, pc_en=1, x_sel=1, alu_fs=10 (PC+1), then goes to EXEC.

EXEC, by opcode:
- 0 LDA: addr_sel=1, mem_rd=1, y_sel=0, alu_fs=00. acc_en=1 only in the mem_ready cycle.
- 1 STO: addr_sel=1, mem_wr=1. Completes on mem_ready.
- 2 ADD: addr_sel=1, mem_rd=1, x_sel=0, y_sel=0, alu_fs=01. acc_en on mem_ready.
- 3 SUB: as ADD, but alu_fs=11.
- 4 JMP: y_sel=1, alu_fs=00, pc_en=1. Single cycle, no memory access, mem_ready ignored.
- 5 JGE: as JMP, but pc_en=!acc_n.
- 6 JNE: as JMP, but pc_en=!acc_z.
- 7 STP: single cycle, no enables, next state HALT.
- 8–F: NOP. Single cycle, no enables, no memory access.
- Leaving EXEC returns to FETCH (HALT for STP).
- A memory opcode stays in EXEC with strobes and selects held until mem_ready=1.

HALT:
- halted=1, all other outputs 0, mem_ready ignored.
- Left only by reset.

## Timing
- While reset_n is low, all outputs are 0 regardless of inputs. The state is forced to FETCH asynchronously, including mid-access or in HALT.
- First FETCH strobe: mem_rd=1 in the first cycle after reset_n rises.
- Latency with zero-wait memory:
  - LDA/STO/ADD/SUB: 2 cycles.
  - JMP/JGE/JNE/STP/NOP: 2 cycles.
  - Each mem_ready=0 cycle adds exactly one cycle to the phase it occurs in.
- Register enables are single-cycle pulses, applied at the rising edge that ends the cycle in which they are asserted.
- mem_rd and mem_wr are never asserted together.
- JGE/JNE sample acc_n/acc_z during the EXEC cycle, i.e. the flags produced by the previous instruction.
- mem_ready asserted outside a memory access has no effect.

## Configuration
- MU0_INSTR_COUNT_EN defined: adds output port instr_count (16 bits).
  - Reset value 0.
  - Increments by 1 at each clock edge that leaves EXEC, including STP and NOP.
  - Wraps FFFF → 0000.
  - Holds in HALT and while waiting on mem_ready.
- MU0_INSTR_COUNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then zero-wait fetch of opcode 0 (LDA):
  - Cycle 1: mem_rd=1, addr_sel=0, ir_en=pc_en=1, alu_fs=10.
  - Cycle 2: addr_sel=1, y_sel=0, acc_en=1.
  - Cycle 3: back in FETCH.
- STO with mem_ready low for 3 EXEC cycles:
  - mem_wr=1 and addr_sel=1 held for 4 cycles.
  - mem_rd=0 throughout; no enables asserted.
- JGE:
  - With acc_n=1: pc_en=0.
  - With acc_n=0: pc_en=1, y_sel=1, alu_fs=00.
  - JNE with acc_z=1: pc_en=0.
- STP:
  - halted=1 from the cycle after EXEC.
  - All strobes stay 0 for 20 cycles with mem_ready toggling.
  - reset_n pulse returns to FETCH with halted=0.
- reset_n asserted mid-wait during ADD EXEC:
  - Outputs go 0 immediately, without waiting for a clock edge.
  - After release, FETCH resumes with mem_rd=1.
- MU0_INSTR_COUNT_EN defined:
  - 5 zero-wait NOP/JMP instructions give instr_count=5.
  - Preloading the counter to FFFF and completing one instruction gives 0000.
